// File: rtl/d1_pe_out_stage_if.sv
// Lane stream from the PE output stage to its consumer.
//   out_data  : quantized 8-bit lane value
//   out_lane  : lane index (0 = y1, 1 = y2, 2 = y3)
//   out_last  : high on lane 2, the final beat of a triple
//   out_valid : beat valid (driven by master)
//   out_ready : beat accepted (driven by slave)
interface d1_pe_out_stage_if;
  logic [7:0] out_data;
  logic [1:0] out_lane;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_lane,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_lane,
    input  out_last,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/d1_pe_out_stage.sv
// Output stage behind the 1D convolution PE: on done, requantizes y1/y2/y3 to
// 8 bits (round, shift, saturate), queues the triple in a DEPTH-entry FIFO and
// streams it one lane per beat.
//   clk, reset_n : clock, async active-low reset (deassertion synchronized)
//   y1, y2, y3   : 16-bit unsigned accumulators, sampled on done
//   done         : capture pulse; shift sampled with it
//   out_if       : lane stream (master side)
//   full         : FIFO holds DEPTH triples
//   drop_err     : sticky, a done found no free slot
//   sat_cnt      : saturating count of lanes clipped to 255
// DEPTH must be a power of two and at least 2.
module d1_pe_out_stage #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [15:0]              y1,
  input  logic [15:0]              y2,
  input  logic [15:0]              y3,
  input  logic                     done,
  input  logic [3:0]               shift,
  d1_pe_out_stage_if.master        out_if,
  output logic                     full,
  output logic                     drop_err,
  output logic [7:0]               sat_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {IDLE, L0, L1, L2} state_t;

  // Round-half-up, shift right, clip to 8 bits; bit 8 flags saturation.
  function automatic logic [8:0] quant(input logic [15:0] y, input logic [3:0] sh);
    logic [16:0] rnd;
    logic [16:0] s;
    logic [16:0] q;
    rnd = (sh == 4'd0) ? 17'd0 : (17'd1 << (sh - 4'd1));
    s   = 17'(y) + rnd;
    q   = s >> sh;
    return (q > 17'd255) ? {1'b1, 8'hFF} : {1'b0, q[7:0]};
  endfunction

  // Reset asserts asynchronously, releases two clocks after reset_n rises.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  state_t          state_q, state_nxt;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_nxt;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_nxt;
  logic [PW-1:0]   occ, occ_nxt;
  logic [7:0]      out_data_q, out_data_nxt;
  logic [1:0]      out_lane_q, out_lane_nxt;
  logic            out_last_q, out_last_nxt;
  logic            out_valid_q, out_valid_nxt;
  logic            full_q, full_nxt;
  logic            drop_err_q, drop_err_nxt;
  logic [7:0]      sat_cnt_q, sat_cnt_nxt;
  logic            hs, pop, push, slot_free;
  logic [8:0]      qv1, qv2, qv3;
  logic [1:0]      sat_n;
  logic [8:0]      sat_sum;
  logic [2:0][7:0] new_triple;
  logic [2:0][7:0] head;
  logic [2:0][7:0] mem [DEPTH];

  // Quantize all three lanes of the incoming capture.
  always_comb begin
    qv1        = quant(y1, shift);
    qv2        = quant(y2, shift);
    qv3        = quant(y3, shift);
    new_triple = {qv3[7:0], qv2[7:0], qv1[7:0]};
    sat_n      = 2'(qv1[8]) + 2'(qv2[8]) + 2'(qv3[8]);
    sat_sum    = 9'(sat_cnt_q) + 9'(sat_n);
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= new_triple;
  end

  // Next-state, pointer and registered-output computation.
  always_comb begin
    state_nxt     = state_q;
    out_data_nxt  = 8'd0;
    out_lane_nxt  = 2'd0;
    out_last_nxt  = 1'b0;
    out_valid_nxt = 1'b0;

    hs         = out_valid_q & out_if.out_ready;
    pop        = hs & (state_q == L2);
    occ        = wr_ptr_q - rd_ptr_q;
    // Popping lane 2 frees a slot in the same cycle, so a full FIFO can still accept.
    slot_free  = (occ != PW'(DEPTH)) | pop;
    push       = done & slot_free;
    wr_ptr_nxt = wr_ptr_q + PW'(push);
    rd_ptr_nxt = rd_ptr_q + PW'(pop);
    occ_nxt    = wr_ptr_nxt - rd_ptr_nxt;
    full_nxt   = (occ_nxt == PW'(DEPTH));

    drop_err_nxt = drop_err_q | (done & ~slot_free);
    sat_cnt_nxt  = sat_cnt_q;
    if (done) sat_cnt_nxt = (sat_sum > 9'd255) ? 8'hFF : sat_sum[7:0];

    case (state_q)
      IDLE:    if (occ_nxt != '0) state_nxt = L0;
      L0:      if (hs) state_nxt = L1;
      L1:      if (hs) state_nxt = L2;
      L2:      if (hs) state_nxt = (occ_nxt != '0) ? L0 : IDLE;
      default: state_nxt = IDLE;
    endcase

    // The next head may be the triple being written this cycle; forward it.
    if (push && (wr_ptr_q[AW-1:0] == rd_ptr_nxt[AW-1:0])) head = new_triple;
    else                                                   head = mem[rd_ptr_nxt[AW-1:0]];

    case (state_nxt)
      L0: begin
        out_valid_nxt = 1'b1;
        out_data_nxt  = head[0];
        out_lane_nxt  = 2'd0;
      end
      L1: begin
        out_valid_nxt = 1'b1;
        out_data_nxt  = head[1];
        out_lane_nxt  = 2'd1;
      end
      L2: begin
        out_valid_nxt = 1'b1;
        out_data_nxt  = head[2];
        out_lane_nxt  = 2'd2;
        out_last_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, pointers and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= 8'd0;
      out_lane_q  <= 2'd0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      full_q      <= 1'b0;
      drop_err_q  <= 1'b0;
      sat_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_nxt;
      wr_ptr_q    <= wr_ptr_nxt;
      rd_ptr_q    <= rd_ptr_nxt;
      out_data_q  <= out_data_nxt;
      out_lane_q  <= out_lane_nxt;
      out_last_q  <= out_last_nxt;
      out_valid_q <= out_valid_nxt;
      full_q      <= full_nxt;
      drop_err_q  <= drop_err_nxt;
      sat_cnt_q   <= sat_cnt_nxt;
    end
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_lane  = out_lane_q;
  assign out_if.out_last  = out_last_q;
  assign out_if.out_valid = out_valid_q;
  assign full             = full_q;
  assign drop_err         = drop_err_q;
  assign sat_cnt          = sat_cnt_q;

endmodule

// File: tb/tb_d1_pe_out_stage.sv
// Directed bench for d1_pe_out_stage (DEPTH = 2).
module tb_d1_pe_out_stage;

  logic        clk;
  logic        reset_n;
  logic [15:0] y1, y2, y3;
  logic        done;
  logic [3:0]  shift;
  logic        full;
  logic        drop_err;
  logic [7:0]  sat_cnt;

  int checks = 0;
  int errors = 0;

  d1_pe_out_stage_if ifc ();

  d1_pe_out_stage #(.DEPTH(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .y1       (y1),
    .y2       (y2),
    .y3       (y3),
    .done     (done),
    .shift    (shift),
    .out_if   (ifc),
    .full     (full),
    .drop_err (drop_err),
    .sat_cnt  (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                      input logic [3:0] sh);
    y1 = a; y2 = b; y3 = c; shift = sh; done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_data",  32'(ifc.out_data),  32'd0);
    check("rst_lane",  32'(ifc.out_lane),  32'd0);
    check("rst_last",  32'(ifc.out_last),  32'd0);
    check("rst_full",  32'(full),          32'd0);
    check("rst_drop",  32'(drop_err),      32'd0);
    check("rst_sat",   32'(sat_cnt),       32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
  endtask

  // Consume one triple with out_ready high, checking each beat in order.
  task automatic expect_triple(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] e [3];
    e[0] = d0; e[1] = d1; e[2] = d2;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      while (!ifc.out_valid && n < 20) begin
        tick();
        n++;
      end
      check("beat_valid", 32'(ifc.out_valid), 32'd1);
      check("beat_data",  32'(ifc.out_data),  32'(e[i]));
      check("beat_lane",  32'(ifc.out_lane),  32'(i));
      check("beat_last",  32'(ifc.out_last),  (i == 2) ? 32'd1 : 32'd0);
      tick();
    end
  endtask

  initial begin
    int extra;
    int beats;
    logic [7:0] rnd_exp [6];

    reset_n = 1'b0;
    y1 = '0; y2 = '0; y3 = '0; shift = '0; done = 1'b0;
    ifc.out_ready = 1'b0;
    do_reset();

    // Rounding with shift 4, lane 3 saturates.
    ifc.out_ready = 1'b1;
    push(16'h0100, 16'h00FF, 16'hFFFF, 4'd4);
    check("t1_latency", 32'(ifc.out_valid), 32'd1);
    check("t1_sat", 32'(sat_cnt), 32'd1);
    expect_triple(8'h10, 8'h10, 8'hFF);
    check("t1_idle", 32'(ifc.out_valid), 32'd0);

    // Shift 0: pass-through with saturation on 0x100.
    push(16'h0042, 16'h0100, 16'h0000, 4'd0);
    check("t2_sat", 32'(sat_cnt), 32'd2);
    expect_triple(8'h42, 8'hFF, 8'h00);

    // Fill and overflow with the consumer stalled.
    ifc.out_ready = 1'b0;
    push(16'd1, 16'd2, 16'd3, 4'd0);
    check("t3_full1", 32'(full), 32'd0);
    push(16'd4, 16'd5, 16'd6, 4'd0);
    check("t3_full2", 32'(full), 32'd1);
    check("t3_drop2", 32'(drop_err), 32'd0);
    push(16'd7, 16'd8, 16'd9, 4'd0);
    check("t3_drop3", 32'(drop_err), 32'd1);
    check("t3_full3", 32'(full), 32'd1);
    check("t3_hold_data", 32'(ifc.out_data), 32'd1);
    check("t3_hold_lane", 32'(ifc.out_lane), 32'd0);
    expect_triple(8'd1, 8'd2, 8'd3);
    expect_triple(8'd4, 8'd5, 8'd6);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (ifc.out_valid) extra++;
      tick();
    end
    check("t3_extra_beats", 32'(extra), 32'd0);
    check("t3_sat_keep", 32'(sat_cnt), 32'd2);
    check("t3_drop_sticky", 32'(drop_err), 32'd1);

    // Push into a full FIFO on the lane-2 handshake: accepted, no bubble.
    do_reset();
    ifc.out_ready = 1'b0;
    push(16'd10, 16'd11, 16'd12, 4'd0);
    push(16'd13, 16'd14, 16'd15, 4'd0);
    check("t4_full", 32'(full), 32'd1);
    ifc.out_ready = 1'b1;
    tick();
    check("t4_l1", 32'(ifc.out_data), 32'd11);
    tick();
    check("t4_l2", 32'(ifc.out_data), 32'd12);
    check("t4_l2_last", 32'(ifc.out_last), 32'd1);
    push(16'd16, 16'd17, 16'd18, 4'd0);
    check("t4_nodrop", 32'(drop_err), 32'd0);
    check("t4_full_after", 32'(full), 32'd1);
    check("t4_nobubble_v", 32'(ifc.out_valid), 32'd1);
    check("t4_nobubble_d", 32'(ifc.out_data), 32'd13);
    expect_triple(8'd13, 8'd14, 8'd15);
    expect_triple(8'd16, 8'd17, 8'd18);
    check("t4_drained", 32'(full), 32'd0);

    // Random backpressure: stable while stalled, lane order preserved.
    ifc.out_ready = 1'b0;
    push(16'd20, 16'd21, 16'd22, 4'd0);
    push(16'd30, 16'd31, 16'd32, 4'd0);
    rnd_exp[0] = 8'd20; rnd_exp[1] = 8'd21; rnd_exp[2] = 8'd22;
    rnd_exp[3] = 8'd30; rnd_exp[4] = 8'd31; rnd_exp[5] = 8'd32;
    beats = 0;
    for (int c = 0; c < 300 && beats < 6; c++) begin
      ifc.out_ready = 1'($urandom_range(0, 1));
      if (ifc.out_valid) begin
        check("rnd_data", 32'(ifc.out_data), 32'(rnd_exp[beats]));
        check("rnd_lane", 32'(ifc.out_lane), 32'(beats % 3));
        if (ifc.out_ready) beats++;
      end
      tick();
    end
    check("rnd_beats", 32'(beats), 32'd6);
    ifc.out_ready = 1'b1;
    tick();
    check("rnd_idle", 32'(ifc.out_valid), 32'd0);

    // Reset during L1 clears everything immediately; no partial triple after.
    ifc.out_ready = 1'b0;
    push(16'd40, 16'd41, 16'd42, 4'd0);
    ifc.out_ready = 1'b1;
    tick();
    check("t6_in_l1", 32'(ifc.out_lane), 32'd1);
    do_reset();
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (ifc.out_valid) extra++;
      tick();
    end
    check("t6_no_partial", 32'(extra), 32'd0);
    push(16'd50, 16'd51, 16'd52, 4'd1);
    expect_triple(8'd25, 8'd26, 8'd26);

    // Largest shift.
    push(16'hFFFF, 16'h4000, 16'h3FFF, 4'd15);
    expect_triple(8'd2, 8'd1, 8'd0);
    check("t7_sat_none", 32'(sat_cnt), 32'd0);

    // sat_cnt saturates at 255 (86 triples x 3 lanes = 258 clips).
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 86; i++) begin
      push(16'hFFFF, 16'hFFFF, 16'hFFFF, 4'd0);
      tick();
      tick();
    end
    check("t8_sat_hold", 32'(sat_cnt), 32'd255);
    check("t8_nodrop", 32'(drop_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
